// File: rtl/d_cache_param_pkg.sv
// d_cache_param_pkg
//   Shared d_cache types and sizing constants.
//   - t_req / t_rd_rsp: the core-side request and read-response structs.
//   - D_ARB_*: sizing of the request arbiter (d_cache_req_arb).
//   - t_arb_tag_entry: one in-flight read slot of the arbiter.
//   - d_arb_next_src: round-robin successor with wrap at num_req-1.
package d_cache_param_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int REG_ID_W = 5;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } t_opcode;

  typedef struct packed {
    logic                valid;
    t_opcode             opcode;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   data;
    logic [REG_ID_W-1:0] reg_id;
  } t_req;

  typedef struct packed {
    logic                valid;
    logic [DATA_W-1:0]   data;
    logic [REG_ID_W-1:0] reg_id;
  } t_rd_rsp;

  // Arbiter sizing. NUM_TAGS must not exceed 2**REG_ID_W because the tag
  // travels to the cache in the reg_id field.
  localparam int D_ARB_NUM_REQ  = 2;
  localparam int D_ARB_NUM_TAGS = 8;
  localparam int D_ARB_TAG_W    = $clog2(D_ARB_NUM_TAGS);
  localparam int D_ARB_SRC_W    = (D_ARB_NUM_REQ > 1) ? $clog2(D_ARB_NUM_REQ) : 1;

  typedef struct packed {
    logic                   busy;
    logic [D_ARB_SRC_W-1:0] src_id;
    logic [REG_ID_W-1:0]    orig_reg_id;
  } t_arb_tag_entry;

  function automatic logic [D_ARB_SRC_W-1:0] d_arb_next_src(
    input logic [D_ARB_SRC_W-1:0] cur,
    input int                     num_req
  );
    if (int'(cur) >= num_req - 1) return '0;
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/d_cache_arb_tag_table.sv
// d_cache_arb_tag_table
//   In-flight read slot table of d_cache_req_arb.
//   Ports:
//     clk, rst        clock, synchronous active-high reset (frees every slot)
//     alloc_en        claim slot alloc_tag for {alloc_src, alloc_reg_id}
//     alloc_tag       lowest-index free slot, from registered state only
//     full            no free slot this cycle
//     lookup_id       reg_id carried by a cache response (the tag)
//     lookup_hit      lookup_id names a slot that is currently busy
//     lookup_src      requester that owns the looked-up slot
//     lookup_orig     original reg_id stored in the looked-up slot
//     free_en         release slot free_tag at the next edge
//     free_tag        slot to release
//   A slot freed this cycle only becomes free after the edge, so the
//   encoder never hands it out in the same cycle it is released.
module d_cache_arb_tag_table
  import d_cache_param_pkg::*;
#(
  parameter int NUM_TAGS = D_ARB_NUM_TAGS,
  parameter int TAG_W    = $clog2(NUM_TAGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_en,
  input  logic [D_ARB_SRC_W-1:0] alloc_src,
  input  logic [REG_ID_W-1:0]    alloc_reg_id,
  output logic [TAG_W-1:0]       alloc_tag,
  output logic                   full,
  input  logic [REG_ID_W-1:0]    lookup_id,
  output logic                   lookup_hit,
  output logic [D_ARB_SRC_W-1:0] lookup_src,
  output logic [REG_ID_W-1:0]    lookup_orig,
  input  logic                   free_en,
  input  logic [TAG_W-1:0]       free_tag
);

  t_arb_tag_entry table_q [NUM_TAGS];
  t_arb_tag_entry lookup_entry;
  logic           lookup_in_range;

  // Lowest free slot: scan downwards so the last hit is the lowest index.
  always_comb begin
    alloc_tag = '0;
    full      = 1'b1;
    for (int t = NUM_TAGS - 1; t >= 0; t--) begin
      if (!table_q[t].busy) begin
        alloc_tag = TAG_W'(t);
        full      = 1'b0;
      end
    end
  end

  // Response tags outside the table count as "not in use".
  always_comb begin
    lookup_in_range = (int'(lookup_id) < NUM_TAGS);
    lookup_entry    = table_q[lookup_id[TAG_W-1:0]];
    lookup_hit      = lookup_in_range && lookup_entry.busy;
    lookup_src      = lookup_entry.src_id;
    lookup_orig     = lookup_entry.orig_reg_id;
  end

  // Allocation targets a free slot and freeing targets a busy one, so the
  // two writes never collide on the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        table_q[t] <= '0;
      end
    end else begin
      if (free_en) begin
        table_q[free_tag].busy <= 1'b0;
      end
      if (alloc_en) begin
        table_q[alloc_tag] <= '{busy: 1'b1, src_id: alloc_src, orig_reg_id: alloc_reg_id};
      end
    end
  end

endmodule

// File: rtl/d_cache_req_arb.sv
// d_cache_req_arb
//   Shares the single d_cache core port between NUM_REQ requesters.
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     req_in[N]        per-requester request
//     req_ready[N]     request i accepted this cycle (one-hot or zero)
//     rsp_out[N]       per-requester read response, original reg_id restored
//     arb2cache_req    request to the cache, reg_id replaced by the tag (RD) or 0 (WR)
//     cache_ready      cache can take a request this cycle
//     cache2arb_rsp    cache read response, reg_id is the tag
//     arb_err          1-cycle pulse: a response carried a tag not in use
//   Configuration macro: D_CACHE_ARB_FIXED_PRIO_EN
//     defined   -> fixed priority, lowest index wins, no round-robin pointer
//     undefined -> round-robin starting at rr_ptr
//   NUM_REQ / NUM_TAGS must match the D_ARB_* values of d_cache_param_pkg,
//   since the tag entry fields are sized there.
//
// Handshake: a request transfers in any cycle where req_in[i].valid and
// req_ready[i] are both high; req_ready is combinational on the same cycle
// and never asserted without valid. The cache side transfers when
// arb2cache_req.valid and cache_ready are both high, which by construction
// is the same cycle as the requester transfer. Responses carry no ready:
// rsp_out[i].valid is a single-cycle strobe that the requester must sink.
module d_cache_req_arb
  import d_cache_param_pkg::*;
#(
  parameter int NUM_REQ  = D_ARB_NUM_REQ,
  parameter int NUM_TAGS = D_ARB_NUM_TAGS
) (
  input  logic               clk,
  input  logic               rst,
  input  t_req               req_in [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  output t_rd_rsp            rsp_out [NUM_REQ],
  output t_req               arb2cache_req,
  input  logic               cache_ready,
  input  t_rd_rsp            cache2arb_rsp,
  output logic               arb_err
);

  localparam int TAG_W = $clog2(NUM_TAGS);
  localparam int SRC_W = D_ARB_SRC_W;

  logic [NUM_REQ-1:0] eligible;
  logic               any_eligible;
  logic               grant_valid;
  logic [SRC_W-1:0]   winner;
  logic               win_is_rd;

  logic               tag_full;
  logic [TAG_W-1:0]   alloc_tag;
  logic               alloc_en;
  logic               lookup_hit;
  logic [SRC_W-1:0]   lookup_src;
  logic [REG_ID_W-1:0] lookup_orig;
  logic               rsp_hit;

  // Writes never need a tag, so only reads are blocked by a full table.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_in[i].valid && ((req_in[i].opcode == OP_WR) || !tag_full);
    end
  end

`ifdef D_CACHE_ARB_FIXED_PRIO_EN
  // Lowest index wins; scanning downwards leaves the lowest hit in winner.
  always_comb begin
    winner       = '0;
    any_eligible = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner       = SRC_W'(i);
        any_eligible = 1'b1;
      end
    end
  end
`else
  logic [SRC_W-1:0] rr_ptr;

  // First eligible at/after rr_ptr. Scanning the offsets downwards leaves
  // the smallest offset (closest to rr_ptr) in winner.
  always_comb begin
    int idx;
    idx          = 0;
    winner       = '0;
    any_eligible = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (eligible[idx]) begin
        winner       = SRC_W'(idx);
        any_eligible = 1'b1;
      end
    end
  end

  // The pointer moves only on an actual transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= d_arb_next_src(winner, NUM_REQ);
    end
  end
`endif

  assign grant_valid = any_eligible && cache_ready;
  assign win_is_rd   = (req_in[winner].opcode == OP_RD);
  assign alloc_en    = grant_valid && win_is_rd;

  always_comb begin
    req_ready     = '0;
    arb2cache_req = '0;
    if (grant_valid) begin
      req_ready[winner]    = 1'b1;
      arb2cache_req        = req_in[winner];
      arb2cache_req.reg_id = win_is_rd ? REG_ID_W'(alloc_tag) : '0;
    end
  end

  d_cache_arb_tag_table #(
    .NUM_TAGS (NUM_TAGS),
    .TAG_W    (TAG_W)
  ) u_tag_table (
    .clk          (clk),
    .rst          (rst),
    .alloc_en     (alloc_en),
    .alloc_src    (winner),
    .alloc_reg_id (req_in[winner].reg_id),
    .alloc_tag    (alloc_tag),
    .full         (tag_full),
    .lookup_id    (cache2arb_rsp.reg_id),
    .lookup_hit   (lookup_hit),
    .lookup_src   (lookup_src),
    .lookup_orig  (lookup_orig),
    .free_en      (rsp_hit),
    .free_tag     (cache2arb_rsp.reg_id[TAG_W-1:0])
  );

  assign rsp_hit = cache2arb_rsp.valid && lookup_hit;

  // Response register: route to the owner with its reg_id restored; any
  // response whose tag is not busy is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_out[i] <= '0;
      end
      arb_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_out[i] <= '0;
        if (rsp_hit && (int'(lookup_src) == i)) begin
          rsp_out[i].valid  <= 1'b1;
          rsp_out[i].data   <= cache2arb_rsp.data;
          rsp_out[i].reg_id <= lookup_orig;
        end
      end
      arb_err <= cache2arb_rsp.valid && !lookup_hit;
    end
  end

endmodule

// File: tb/tb_d_cache_req_arb.sv
// tb_d_cache_req_arb
//   Directed scenarios followed by randomized traffic, all checked against a
//   slot-level reference model (busy flags, owner, original reg_id, and the
//   next preferred requester). Build with +define+D_CACHE_ARB_FIXED_PRIO_EN
//   to check the fixed-priority variant.
module tb_d_cache_req_arb;
  import d_cache_param_pkg::*;

  localparam int NUM_REQ  = D_ARB_NUM_REQ;
  localparam int NUM_TAGS = D_ARB_NUM_TAGS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  t_req               req_in [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;
  t_rd_rsp            rsp_out [NUM_REQ];
  t_req               arb2cache_req;
  logic               cache_ready;
  t_rd_rsp            cache2arb_rsp;
  logic               arb_err;

  d_cache_req_arb #(
    .NUM_REQ  (NUM_REQ),
    .NUM_TAGS (NUM_TAGS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_in        (req_in),
    .req_ready     (req_ready),
    .rsp_out       (rsp_out),
    .arb2cache_req (arb2cache_req),
    .cache_ready   (cache_ready),
    .cache2arb_rsp (cache2arb_rsp),
    .arb_err       (arb_err)
  );

  // ---------------- scoreboard counters ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    n_assert++;
    assert (obs === want)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // ---------------- reference model ----------------
  bit                  m_busy [NUM_TAGS];
  int                  m_src  [NUM_TAGS];
  logic [REG_ID_W-1:0] m_orig [NUM_TAGS];
  int                  m_rr;

  // Combinational values seen in the last cycle, for scenario checks.
  logic [NUM_REQ-1:0]  obs_ready;
  t_req                obs_req;

  task automatic model_reset();
    for (int t = 0; t < NUM_TAGS; t++) m_busy[t] = 1'b0;
    m_rr = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    for (int i = 0; i < NUM_REQ; i++) req_in[i] = '0;
    cache2arb_rsp = '0;
    cache_ready   = 1'b1;
  endtask

  task automatic set_req(input int i, input t_opcode op, input int rid);
    req_in[i].valid   = 1'b1;
    req_in[i].opcode  = op;
    req_in[i].address = $urandom;
    req_in[i].data    = $urandom;
    req_in[i].reg_id  = REG_ID_W'(rid);
  endtask

  task automatic clr_req(input int i);
    req_in[i] = '0;
  endtask

  task automatic set_rsp(input int tag);
    cache2arb_rsp.valid  = 1'b1;
    cache2arb_rsp.data   = $urandom;
    cache2arb_rsp.reg_id = REG_ID_W'(tag);
  endtask

  // One clock cycle. Entered 1 time unit after a rising edge with inputs
  // already driven; returns 1 time unit after the next rising edge.
  task automatic run_cycle();
    int                 win;
    int                 lf;
    int                 idx;
    int                 tag;
    bit                 any_free;
    bit                 hit;
    logic [NUM_REQ-1:0] exp_ready;
    t_req               exp_req;
    t_rd_rsp            exp_rsp [NUM_REQ];
    logic               exp_err;

    #1;
    any_free = 1'b0;
    lf       = 0;
    for (int t = NUM_TAGS - 1; t >= 0; t--) begin
      if (!m_busy[t]) begin
        any_free = 1'b1;
        lf       = t;
      end
    end

    win = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef D_CACHE_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (m_rr + k) % NUM_REQ;
`endif
      if (win < 0 && req_in[idx].valid && (req_in[idx].opcode == OP_WR || any_free)) win = idx;
    end
    if (!cache_ready) win = -1;

    exp_ready = '0;
    exp_req   = '0;
    if (win >= 0) begin
      exp_ready[win] = 1'b1;
      exp_req        = req_in[win];
      exp_req.reg_id = (req_in[win].opcode == OP_RD) ? REG_ID_W'(lf) : '0;
    end

    obs_ready = req_ready;
    obs_req   = arb2cache_req;
    chk("req_ready", 128'(obs_ready), 128'(exp_ready));
    chk("arb2cache_req", 128'(obs_req), 128'(exp_req));

    tag = int'(cache2arb_rsp.reg_id);
    hit = 1'b0;
    if (cache2arb_rsp.valid && tag < NUM_TAGS) hit = m_busy[tag];
    for (int i = 0; i < NUM_REQ; i++) exp_rsp[i] = '0;
    exp_err = cache2arb_rsp.valid && !hit;
    if (hit) begin
      exp_rsp[m_src[tag]].valid  = 1'b1;
      exp_rsp[m_src[tag]].data   = cache2arb_rsp.data;
      exp_rsp[m_src[tag]].reg_id = m_orig[tag];
    end

    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) exp_rsp[i] = '0;
      exp_err = 1'b0;
      model_reset();
    end else begin
      if (hit) m_busy[tag] = 1'b0;
      if (win >= 0) begin
        if (req_in[win].opcode == OP_RD) begin
          m_busy[lf] = 1'b1;
          m_src[lf]  = win;
          m_orig[lf] = req_in[win].reg_id;
        end
        m_rr = (win + 1) % NUM_REQ;
      end
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      chk($sformatf("rsp_out[%0d]", i), 128'(rsp_out[i]), 128'(exp_rsp[i]));
    end
    chk("arb_err", 128'(arb_err), 128'(exp_err));
  endtask

  // Respond to every slot the model still holds.
  task automatic drain();
    for (int t = 0; t < NUM_TAGS; t++) begin
      if (m_busy[t]) begin
        idle_inputs();
        set_rsp(t);
        run_cycle();
      end
    end
    idle_inputs();
    run_cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nbusy;
    int pick;
    int r;
    int busy_list [$];

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    for (int i = 0; i < NUM_REQ; i++) chk($sformatf("reset_rsp_out[%0d]", i), 128'(rsp_out[i]), 128'(0));
    chk("reset_arb_err", 128'(arb_err), 128'(0));
    chk("reset_req_ready", 128'(req_ready), 128'(0));
    chk("reset_req_valid", 128'(arb2cache_req.valid), 128'(0));
    rst = 1'b0;
    model_reset();

    // Scenario: both requesters write continuously.
    set_req(0, OP_WR, 1);
    set_req(1, OP_WR, 2);
    for (int k = 0; k < 4; k++) begin
      run_cycle();
`ifdef D_CACHE_ARB_FIXED_PRIO_EN
      chk($sformatf("wr_grant_%0d", k), 128'(obs_ready), 128'(2'b01));
`else
      chk($sformatf("wr_grant_%0d", k), 128'(obs_ready), (k % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
`endif
      chk($sformatf("wr_tag_%0d", k), 128'(obs_req.reg_id), 128'(0));
    end

    // Scenario: single read, tag 0, response restores reg_id 5.
    idle_inputs();
    set_req(0, OP_RD, 5);
    run_cycle();
    chk("rd_ready", 128'(obs_ready), 128'(2'b01));
    chk("rd_tag", 128'(obs_req.reg_id), 128'(0));
    idle_inputs();
    set_rsp(0);
    run_cycle();
    chk("rd_rsp_valid", 128'(rsp_out[0].valid), 128'(1));
    chk("rd_rsp_reg_id", 128'(rsp_out[0].reg_id), 128'(5));

    // Scenario: fill all slots, owners 0,0,1,1,0,0,1,1, reg_id 16+k.
    for (int k = 0; k < NUM_TAGS; k++) begin
      idle_inputs();
      set_req((k >> 1) & 1, OP_RD, 16 + k);
      run_cycle();
      chk($sformatf("fill_tag_%0d", k), 128'(obs_req.reg_id), 128'(k));
    end
    idle_inputs();
    set_req(0, OP_WR, 3);
    set_req(1, OP_RD, 9);
    run_cycle();
    chk("full_wr_only", 128'(obs_ready), 128'(2'b01));
    clr_req(0);
    set_rsp(3);
    run_cycle();
    chk("full_same_cycle_free", 128'(obs_ready), 128'(2'b00));
    chk("rsp_tag3_valid", 128'(rsp_out[1].valid), 128'(1));
    chk("rsp_tag3_reg_id", 128'(rsp_out[1].reg_id), 128'(19));
    cache2arb_rsp = '0;
    run_cycle();
    chk("refill_ready", 128'(obs_ready), 128'(2'b10));
    chk("refill_tag", 128'(obs_req.reg_id), 128'(3));

    // Scenario: out-of-order responses to tags 2 (Req1) and 0 (Req0).
    idle_inputs();
    set_rsp(2);
    run_cycle();
    chk("ooo_rsp1_valid", 128'(rsp_out[1].valid), 128'(1));
    chk("ooo_rsp1_reg_id", 128'(rsp_out[1].reg_id), 128'(18));
    chk("ooo_rsp0_quiet", 128'(rsp_out[0].valid), 128'(0));
    set_rsp(0);
    run_cycle();
    chk("ooo_rsp0_valid", 128'(rsp_out[0].valid), 128'(1));
    chk("ooo_rsp0_reg_id", 128'(rsp_out[0].reg_id), 128'(16));
    drain();

    // Scenario: cache stalls for 3 cycles; nothing granted or allocated.
    set_req(1, OP_WR, 0);
    run_cycle();
    idle_inputs();
    set_req(0, OP_RD, 7);
    set_req(1, OP_WR, 0);
    cache_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      run_cycle();
      chk($sformatf("stall_ready_%0d", k), 128'(obs_ready), 128'(0));
      chk($sformatf("stall_valid_%0d", k), 128'(obs_req.valid), 128'(0));
    end
    cache_ready = 1'b1;
    run_cycle();
    chk("stall_release_ready", 128'(obs_ready), 128'(2'b01));
    chk("stall_release_tag", 128'(obs_req.reg_id), 128'(0));
    drain();

    // Scenario: reset with tags 1 and 4 busy, then a stale response to tag 4.
    for (int k = 0; k < 5; k++) begin
      idle_inputs();
      set_req(0, OP_RD, k + 1);
      run_cycle();
    end
    idle_inputs();
    set_rsp(0); run_cycle();
    set_rsp(2); run_cycle();
    set_rsp(3); run_cycle();
    idle_inputs();
    rst = 1'b1;
    run_cycle();
    run_cycle();
    rst = 1'b0;
    set_rsp(4);
    run_cycle();
    chk("stale_err", 128'(arb_err), 128'(1));
    chk("stale_rsp0", 128'(rsp_out[0].valid), 128'(0));
    chk("stale_rsp1", 128'(rsp_out[1].valid), 128'(0));
    idle_inputs();
    run_cycle();
    chk("stale_err_pulse", 128'(arb_err), 128'(0));

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 99) < 60) begin
          set_req(i, ($urandom_range(0, 1) == 0) ? OP_RD : OP_WR, int'($urandom_range(0, 31)));
        end else begin
          clr_req(i);
        end
      end
      cache_ready = ($urandom_range(0, 3) != 0);
      busy_list.delete();
      for (int t = 0; t < NUM_TAGS; t++) if (m_busy[t]) busy_list.push_back(t);
      nbusy = busy_list.size();
      r = int'($urandom_range(0, 9));
      cache2arb_rsp = '0;
      if (r < 5 && nbusy > 0) begin
        pick = int'($urandom_range(0, nbusy - 1));
        set_rsp(busy_list[pick]);
      end else if (r == 5) begin
        set_rsp(int'($urandom_range(0, 31)));
      end
      rst = ($urandom_range(0, 199) == 0);
      run_cycle();
    end
    rst = 1'b0;
    idle_inputs();
    run_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
